// File: rtl/lcd_digits_driver_if.sv
// Write-only HD44780 pin bundle: enable strobe, read/write select,
// register select and the 8-bit data bus.
interface lcd_digits_driver_if;
    logic       E_out;
    logic       RW_out;
    logic       RS_out;
    logic [7:0] DB_out;

    // The driver owns the pins; the LCD side only observes them.
    modport master (output E_out, RW_out, RS_out, DB_out);
    modport slave  (input  E_out, RW_out, RS_out, DB_out);
endinterface

// File: rtl/lcd_digits_driver.sv
// Character-LCD driver: power-up init, then renders NDIGITS 4-bit values as
// ASCII at START_ADDR. Digits are snapshotted per frame so a frame never
// mixes old and new values. A new frame starts when the live digits differ
// from the snapshot, or on a refresh request while idle.
module lcd_digits_driver #(
    parameter int       NDIGITS     = 4,
    parameter bit [6:0] START_ADDR  = 7'h00,
    parameter bit       HEX_MODE    = 1'b1,
    parameter int       INIT_WAIT   = 750000,
    parameter int       E_CYCLES    = 12,
    parameter int       WAIT_CYCLES = 2000,
    parameter int       CLR_WAIT    = 82000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   digits,
    input  logic                   refresh,
    lcd_digits_driver_if.master    lcd,
    output logic                   ready,
    output logic                   frame_done
);

    // One shared counter covers power-up delay, E pulse width and every wait.
    localparam int MAX_A    = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int MAX_B    = (WAIT_CYCLES > E_CYCLES) ? WAIT_CYCLES : E_CYCLES;
    localparam int MAX_CNT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

    typedef enum logic [2:0] {S_POWERUP, S_INIT, S_FRAME, S_DATA, S_IDLE} top_e;
    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD, P_WAIT} phase_e;

    top_e                 top_q, top_d;
    phase_e               phase_q, phase_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4:0]           idx_q, idx_d;
    logic [4*NDIGITS-1:0] snap_q, snap_d;
    logic                 e_q, e_d;
    logic                 rs_q, rs_d;
    logic [7:0]           db_q, db_d;
    logic                 ready_q, ready_d;
    logic                 fd_q, fd_d;

    // Initialisation command for a given step of the init sequence.
    function automatic logic [7:0] init_cmd(input logic [4:0] step);
        case (step)
            5'd0:    return 8'h38;
            5'd1:    return 8'h0C;
            5'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // ASCII rendering of one digit value.
    function automatic logic [7:0] digit_char(input logic [3:0] v);
        if (v < 4'd10)  return 8'h30 + {4'h0, v};
        else if (HEX_MODE) return 8'h41 + {4'h0, v} - 8'd10;
        else            return 8'h2D;
    endfunction

    // State register and registered LCD/status outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the snapshot is plain state, not a memory, so it is reset like the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= S_POWERUP;
            phase_q <= P_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            ready_q <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            top_q   <= top_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            ready_q <= ready_d;
            fd_q    <= fd_d;
        end
    end

    // Next-state: top-level sequencing plus the SETUP/PULSE/HOLD/WAIT write primitive.
    always_comb begin
        logic start_frame;
        logic write_done;
        int   wait_len;
        int   next_j;

        // NOTE: every variable gets a default first so no path leaves a latch behind.
        top_d       = top_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        e_d         = 1'b0;
        rs_d        = rs_q;
        db_d        = db_q;
        ready_d     = 1'b0;
        fd_d        = 1'b0;
        start_frame = 1'b0;
        write_done  = 1'b0;
        next_j      = 0;
        // Clear-display needs the long settle time; everything else the short one.
        wait_len    = (!rs_q && db_q == 8'h01) ? CLR_WAIT : WAIT_CYCLES;

        case (top_q)
            S_POWERUP: begin
                if (int'(cnt_q) + 1 >= INIT_WAIT) begin
                    top_d   = S_INIT;
                    idx_d   = '0;
                    db_d    = init_cmd(5'd0);
                    rs_d    = 1'b0;
                    phase_d = P_SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (refresh || digits != snap_q) start_frame = 1'b1;
                else                             ready_d     = 1'b1;
            end
            default: begin
                case (phase_q)
                    P_SETUP: begin
                        cnt_d = '0;
                        if (E_CYCLES == 0) begin
                            phase_d = P_HOLD;
                        end else begin
                            phase_d = P_PULSE;
                            e_d     = 1'b1;
                        end
                    end
                    P_PULSE: begin
                        if (int'(cnt_q) + 1 >= E_CYCLES) begin
                            phase_d = P_HOLD;
                            cnt_d   = '0;
                        end else begin
                            e_d   = 1'b1;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    P_HOLD: begin
                        if (wait_len == 0) begin
                            write_done = 1'b1;
                        end else begin
                            phase_d = P_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        if (int'(cnt_q) + 1 >= wait_len) write_done = 1'b1;
                        else                             cnt_d = cnt_q + CW'(1);
                    end
                endcase
            end
        endcase

        // Byte finished: pick the next byte or leave the write sequence.
        if (write_done) begin
            phase_d = P_SETUP;
            cnt_d   = '0;
            case (top_q)
                S_INIT: begin
                    if (idx_q == 5'd3) begin
                        start_frame = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        db_d  = init_cmd(idx_q + 5'd1);
                        rs_d  = 1'b0;
                    end
                end
                S_FRAME: begin
                    top_d = S_DATA;
                    idx_d = '0;
                    rs_d  = 1'b1;
                    db_d  = digit_char(snap_q[4*(NDIGITS-1) +: 4]);
                end
                S_DATA: begin
                    if (int'(idx_q) == NDIGITS - 1) begin
                        top_d   = S_IDLE;
                        fd_d    = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        next_j = NDIGITS - 2 - int'(idx_q);
                        idx_d  = idx_q + 5'd1;
                        db_d   = digit_char(snap_q[4*next_j +: 4]);
                    end
                end
                default: ;
            endcase
        end

        // Frame entry: freeze the digits, then send the DDRAM address command.
        if (start_frame) begin
            top_d   = S_FRAME;
            snap_d  = digits;
            db_d    = {1'b1, START_ADDR};
            rs_d    = 1'b0;
            phase_d = P_SETUP;
            cnt_d   = '0;
        end
    end

    assign lcd.E_out  = e_q;
    assign lcd.RW_out = 1'b0;
    assign lcd.RS_out = rs_q;
    assign lcd.DB_out = db_q;
    assign ready      = ready_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_lcd_digits_driver.sv
// Randomised scoreboard bench: a hex-mode and a decimal-mode driver run in
// lockstep; expected bytes and write spacing come from a high-level model.
module tb_lcd_digits_driver;

    localparam int EC       = 2;
    localparam int WC       = 4;
    localparam int CC       = 8;
    localparam int GAP      = 2 + EC + WC;
    localparam int GAP_CLR  = 2 + EC + CC;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        refresh;
    logic [15:0] digits;
    logic        ready_h, ready_d, fd_h, fd_d;

    lcd_digits_driver_if bus_h ();
    lcd_digits_driver_if bus_d ();

    lcd_digits_driver #(.NDIGITS(4), .START_ADDR(7'h00), .HEX_MODE(1'b1), .INIT_WAIT(20),
                        .E_CYCLES(EC), .WAIT_CYCLES(WC), .CLR_WAIT(CC)) u_hex (
        .clk(clk), .reset(reset), .digits(digits), .refresh(refresh),
        .lcd(bus_h), .ready(ready_h), .frame_done(fd_h));

    lcd_digits_driver #(.NDIGITS(4), .START_ADDR(7'h00), .HEX_MODE(1'b0), .INIT_WAIT(20),
                        .E_CYCLES(EC), .WAIT_CYCLES(WC), .CLR_WAIT(CC)) u_dec (
        .clk(clk), .reset(reset), .digits(digits), .refresh(refresh),
        .lcd(bus_d), .ready(ready_d), .frame_done(fd_d));

    always #5 clk = ~clk;

    exp_t q_h[$];
    exp_t q_d[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_frames = 0;
    int   fd_cnt[2];
    int   rise_cnt[2];
    logic e_prev[2];
    logic fd_prev[2];
    int   hi_cnt[2];
    int   last_rise[2];
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference character table: display glyph for each digit value.
    function automatic logic [7:0] model_char(input logic [3:0] v, input bit hex);
        string glyphs;
        glyphs = "0123456789ABCDEF";
        if (v < 10 || hex) return glyphs[v];
        return 8'h2D;
    endfunction

    function automatic void push_cmd(input logic [7:0] b, input int gap);
        q_h.push_back('{1'b0, b, gap});
        q_d.push_back('{1'b0, b, gap});
    endfunction

    // One frame: address command, then digits from most to least significant.
    function automatic void push_frame(input logic [15:0] d, input int first_gap);
        push_cmd(8'h80, first_gap);
        for (int j = 3; j >= 0; j--) begin
            q_h.push_back('{1'b1, model_char(d[4*j +: 4], 1'b1), GAP});
            q_d.push_back('{1'b1, model_char(d[4*j +: 4], 1'b0), GAP});
        end
        exp_frames++;
    endfunction

    function automatic void push_init(input logic [15:0] d);
        push_cmd(8'h38, -1);
        push_cmd(8'h0C, GAP);
        push_cmd(8'h01, GAP);
        push_cmd(8'h06, GAP_CLR);
        push_frame(d, GAP);
    endfunction

    // Monitor: checks every write strobe and frame_done pulse against the queues.
    always @(negedge clk) begin : monitor
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic       e, rw, rs, rdy, fd;
            logic [7:0] db;
            exp_t       ex;
            int         qsz;
            e   = (i == 0) ? bus_h.E_out  : bus_d.E_out;
            rw  = (i == 0) ? bus_h.RW_out : bus_d.RW_out;
            rs  = (i == 0) ? bus_h.RS_out : bus_d.RS_out;
            db  = (i == 0) ? bus_h.DB_out : bus_d.DB_out;
            rdy = (i == 0) ? ready_h : ready_d;
            fd  = (i == 0) ? fd_h : fd_d;
            if (reset) begin
                e_prev[i]    = 1'b0;
                fd_prev[i]   = 1'b0;
                hi_cnt[i]    = 0;
                last_rise[i] = cyc;
            end else begin
                if (e && !e_prev[i]) begin
                    rise_cnt[i]++;
                    check("rw_low", {31'd0, rw}, 0);
                    check("ready_busy", {31'd0, rdy}, 0);
                    qsz = (i == 0) ? q_h.size() : q_d.size();
                    if (qsz == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write inst%0d: got rs=%0b db=%0h expected no write", i, rs, db);
                    end else begin
                        ex = (i == 0) ? q_h.pop_front() : q_d.pop_front();
                        check("rs", {31'd0, rs}, {31'd0, ex.rs});
                        check("db", {24'd0, db}, {24'd0, ex.db});
                        if (ex.gap >= 0) check("write_gap", cyc - last_rise[i], ex.gap);
                    end
                    last_rise[i] = cyc;
                end
                if (e) hi_cnt[i]++;
                if (!e && e_prev[i]) begin
                    check("e_width", hi_cnt[i], EC);
                    hi_cnt[i] = 0;
                end
                if (fd) begin
                    if (fd_prev[i]) begin
                        check("fd_width", 2, 1);
                    end else begin
                        fd_cnt[i]++;
                        check("ready_at_done", {31'd0, rdy}, 1);
                    end
                end
                e_prev[i]  = e;
                fd_prev[i] = fd;
            end
        end
    end

    task automatic wait_frames(input int budget);
        while (fd_cnt[0] < exp_frames && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        check("frames_hex", fd_cnt[0], exp_frames);
        check("frames_dec", fd_cnt[1], exp_frames);
    endtask

    task automatic idle_quiet(input int n);
        repeat (n) @(negedge clk);
        check("queue_hex_empty", q_h.size(), 0);
        check("queue_dec_empty", q_d.size(), 0);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          hi;
        int          budget;
        int          base;
        logic [15:0] nd;
        for (int i = 0; i < 2; i++) begin
            fd_cnt[i] = 0; rise_cnt[i] = 0; e_prev[i] = 1'b0;
            fd_prev[i] = 1'b0; hi_cnt[i] = 0; last_rise[i] = 0;
        end
        reset   = 1'b1;
        refresh = 1'b0;
        digits  = 16'h4321;
        #3;
        check("rst_e",     {31'd0, bus_h.E_out},  0);
        check("rst_rw",    {31'd0, bus_h.RW_out}, 0);
        check("rst_rs",    {31'd0, bus_h.RS_out}, 0);
        check("rst_db",    {24'd0, bus_h.DB_out}, 0);
        check("rst_ready", {31'd0, ready_h},      0);
        check("rst_fd",    {31'd0, fd_h},         0);

        // Power-up, init sequence and first unconditional frame.
        push_init(digits);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            hi += int'(bus_h.E_out);
        end
        check("powerup_quiet", hi, 0);
        wait_frames(2000);
        idle_quiet(100);

        // Digit change in idle, hex letters and decimal dash rendering.
        digits = 16'hFA09;
        push_frame(digits, -1);
        wait_frames(1000);
        idle_quiet(20);

        // Refresh with unchanged digits; mid-frame change and refresh.
        push_frame(digits, -1);
        base = rise_cnt[0];
        pulse_refresh();
        budget = 500;
        while (rise_cnt[0] < base + 3 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reach_second_data", rise_cnt[0], base + 3);
        digits = 16'h5555;
        push_frame(digits, -1);
        pulse_refresh();
        wait_frames(1000);
        idle_quiet(100);

        // Refresh and change in the same idle cycle: one frame.
        digits = 16'h1234;
        push_frame(digits, -1);
        pulse_refresh();
        wait_frames(1000);
        idle_quiet(50);

        // Random digit patterns.
        for (int k = 0; k < 8; k++) begin
            nd = 16'($urandom);
            push_frame(nd, -1);
            if (nd == digits || $urandom_range(0, 3) == 0) begin
                digits = nd;
                pulse_refresh();
            end else begin
                digits = nd;
            end
            wait_frames(1000);
        end
        idle_quiet(50);

        // Reset while E is high, then full restart.
        digits = 16'hBEEF;
        push_frame(digits, -1);
        budget = 500;
        while (!bus_h.E_out && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("saw_e_high", {31'd0, bus_h.E_out}, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_e",  {31'd0, bus_h.E_out}, 0);
        check("async_db", {24'd0, bus_h.DB_out}, 0);
        check("async_rs", {31'd0, bus_h.RS_out}, 0);
        check("async_e_dec", {31'd0, bus_d.E_out}, 0);
        q_h.delete();
        q_d.delete();
        exp_frames = fd_cnt[0];
        push_init(digits);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_frames(2000);
        idle_quiet(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_digits_driver.md
Name: lcd_digits_driver

Overview:
- Parametrised successor to the team's fixed 4-digit character-LCD driver. Drives an HD44780-compatible module over an 8-bit write-only bus.
- Runs the power-up initialisation sequence, then writes NDIGITS 4-bit values as ASCII characters starting at a configurable DDRAM address.
- Adds hex/decimal rendering, tear-free snapshotting, change-triggered refresh and status outputs.
- Sits between the counter datapath and the LCD pins.

Parameters:
- NDIGITS, 4: number of displayed digits (1..16).
- START_ADDR, 7'h00: DDRAM address of the leftmost digit.
- HEX_MODE, 1: 1 renders values 10..15 as 'A'..'F'; 0 renders them as '-' (8'h2D).
- INIT_WAIT, 750000: power-up delay in clk cycles before the first command.
- E_CYCLES, 12: cycles E_out is held high per write.
- WAIT_CYCLES, 2000: post-write wait for ordinary commands and data.
- CLR_WAIT, 82000: post-write wait after the clear-display command.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits  in  4*NDIGITS  digit values; digit i = digits[4i+3:4i]; digit NDIGITS-1 is displayed leftmost.
- refresh  in  1  single-cycle request to rewrite the display even if digits are unchanged.
- E_out  out  1  LCD enable strobe.
- RW_out  out  1  LCD read/write select; constant 0 (write only).
- RS_out  out  1  LCD register select; 0 = command, 1 = data.
- DB_out  out  8  LCD data bus.
- ready  out  1  high only in IDLE.
- frame_done  out  1  one-cycle pulse after the last digit's wait completes.

Behaviour:
- Reset (asynchronous, active-high), takes effect immediately, including mid-write:
  - E_out=0, RW_out=0, RS_out=0, DB_out=8'h00, ready=0, frame_done=0.
  - State=POWERUP, all counters cleared, snapshot register cleared to 0.
- Write primitive (all outputs registered); for each byte:
  - SETUP: 1 cycle, RS_out/DB_out valid, E_out=0.
  - PULSE: E_CYCLES cycles, E_out=1.
  - HOLD: 1 cycle, E_out=0, RS_out/DB_out unchanged.
  - WAIT: WAIT_CYCLES cycles, or CLR_WAIT if the byte was 8'h01 with RS=0. DB_out/RS_out keep their value.
- Top-level states:
  - POWERUP: count INIT_WAIT cycles after reset release, then go to INIT.
  - INIT: commands 8'h38, 8'h0C, 8'h01, 8'h06 in order (RS=0), then go to FRAME.
  - FRAME: on entry, latch digits into the snapshot, then write address command 8'h80|START_ADDR (RS=0).
  - DATA: NDIGITS data writes (RS=1), snapshot digit NDIGITS-1 down to 0. After the last WAIT, pulse frame_done and go to IDLE.
  - IDLE: ready=1. Go to FRAME on the next cycle if refresh=1 or digits != snapshot.
- The first frame after INIT is unconditional.
- Digit encoding: value 0..9 -> 8'h30+value. Value 10..15 -> 8'h41+(value-10) if HEX_MODE, else 8'h2D.
- Tear-free display: digits changing during FRAME/DATA do not affect the current frame. The change is detected in IDLE and triggers a new frame.
- refresh is ignored outside IDLE and is not queued.
- A refresh and a digit change in the same IDLE cycle produce one frame.
- Counters must be sized for the largest of INIT_WAIT, CLR_WAIT and WAIT_CYCLES. Zero wait values are legal and mean no WAIT cycles.
- Write cycle length: 2+E_CYCLES+wait. Frame length: (NDIGITS+1) write cycles.

Test Plan:
All scenarios use NDIGITS=4, INIT_WAIT=20, E_CYCLES=2, WAIT_CYCLES=4, CLR_WAIT=8, HEX_MODE=1.

1. Reset released, digits=16'h4321 -> E_out stays 0 for 20 cycles. Command bytes seen at E rising edges: 38, 0C, 01, 06, then 80. The gap after 01 is 8 wait cycles; after the others it is 4. RW_out is always 0.
2. Continuing scenario 1 -> data bytes 34, 33, 32, 31 with RS_out=1. frame_done pulses once for 1 cycle, then ready=1. No further E pulses while digits are stable.
3. In IDLE set digits=16'hFA09 -> new frame: 80, 46, 41, 30, 39. Rerun with HEX_MODE=0 -> 80, 2D, 2D, 30, 39.
4. Change digits to 16'h5555 during the second data write of a frame -> that frame completes with the old snapshot. Next frame shows 35, 35, 35, 35. A refresh pulse asserted mid-frame is dropped.
5. Assert reset while E_out=1 -> E_out and DB_out go to 0 without waiting for a clock edge. After release, the full POWERUP+INIT sequence repeats.
6. refresh pulse in IDLE with unchanged digits -> exactly one frame is rewritten with identical bytes, followed by one frame_done pulse.
